// File: rtl/vc_dest_arbiter_pkg.sv
// Shared definitions for the VC-to-destination scheduler.
//   - Default widths (DATA_W, DEST_BIT, WEIGHT_W)
//   - FSM state codes
//   - VC index constants
package vc_dest_arbiter_pkg;

  localparam int DATA_W   = 6;
  localparam int DEST_BIT = 4;
  localparam int WEIGHT_W = 3;

  localparam int VC0 = 0;
  localparam int VC1 = 1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'b000,
    ST_INIT   = 3'b001,
    ST_IDLE   = 3'b010,
    ST_ACTIVE = 3'b011
  } state_t;

endpackage

// File: rtl/vc_dest_arbiter_wrr_grant.sv
// Weighted round-robin grant between two virtual channels.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   i_en            - grants allowed this cycle
//   i_elig[1:0]     - per-VC eligibility (non-empty and destination not almost full)
//   i_weight_vc0/1  - consecutive grants allowed per VC (already forced >= 1)
//   o_grant[1:0]    - one-hot grant (all zero when nothing granted)
// Holds the grant counter and the last-grant pointer internally.
module vc_dest_arbiter_wrr_grant
  import vc_dest_arbiter_pkg::*;
#(
  parameter int WEIGHT_W = vc_dest_arbiter_pkg::WEIGHT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic [1:0]          i_elig,
  input  logic [WEIGHT_W-1:0] i_weight_vc0,
  input  logic [WEIGHT_W-1:0] i_weight_vc1,
  output logic [1:0]          o_grant
);

  logic                r_cur_vc;
  logic [WEIGHT_W-1:0] r_cnt;

  logic                w_cur_elig;
  logic                w_oth_elig;
  logic [WEIGHT_W-1:0] w_weight;
  logic [1:0]          w_grant;
  logic                w_cur_nxt;
  logic [WEIGHT_W-1:0] w_cnt_nxt;

  assign w_cur_elig = i_elig[r_cur_vc];
  assign w_oth_elig = i_elig[~r_cur_vc];
  assign w_weight   = r_cur_vc ? i_weight_vc1 : i_weight_vc0;

  // Priority: stay on current VC within quota, else switch, else stay
  // with a fresh quota when the other VC cannot take the slot.
  always_comb begin
    w_grant   = '0;
    w_cur_nxt = r_cur_vc;
    w_cnt_nxt = r_cnt;
    if (w_cur_elig && (r_cnt < w_weight)) begin
      w_grant[r_cur_vc] = 1'b1;
      w_cnt_nxt         = (&r_cnt) ? r_cnt : r_cnt + WEIGHT_W'(1);
    end else if (w_oth_elig) begin
      w_grant[~r_cur_vc] = 1'b1;
      w_cur_nxt          = ~r_cur_vc;
      w_cnt_nxt          = WEIGHT_W'(1);
    end else if (w_cur_elig) begin
      w_grant[r_cur_vc] = 1'b1;
      w_cnt_nxt         = WEIGHT_W'(1);
    end
  end

  assign o_grant = i_en ? w_grant : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_cur_vc <= 1'(VC0);
    end else if (i_en && (|w_grant)) begin
      r_cnt    <= w_cnt_nxt;
      r_cur_vc <= w_cur_nxt;
    end
  end

endmodule

// File: rtl/vc_dest_arbiter.sv
// Scheduler moving words from two VC FIFOs into two destination FIFOs.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   init                        - level; holds the block in INIT, latching weights
//   cfg_weight_VC0/VC1          - per-VC weights (0 treated as 1)
//   data_in_VC0/VC1, empty_VCx  - show-ahead heads of the VC FIFOs
//   almost_full_D0/D1           - destination backpressure
//   pop_VC0/VC1                 - combinational pops (same cycle as grant)
//   push_D0/D1, data_out        - registered push one cycle after the pop
//   state, idle                 - FSM state code and registered IDLE flag
module vc_dest_arbiter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int DATA_W   = vc_dest_arbiter_pkg::DATA_W,
  parameter int DEST_BIT = vc_dest_arbiter_pkg::DEST_BIT,
  parameter int WEIGHT_W = vc_dest_arbiter_pkg::WEIGHT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] cfg_weight_VC0,
  input  logic [WEIGHT_W-1:0] cfg_weight_VC1,
  input  logic [DATA_W-1:0]   data_in_VC0,
  input  logic [DATA_W-1:0]   data_in_VC1,
  input  logic                empty_VC0,
  input  logic                empty_VC1,
  input  logic                almost_full_D0,
  input  logic                almost_full_D1,
  output logic                pop_VC0,
  output logic                pop_VC1,
  output logic                push_D0,
  output logic                push_D1,
  output logic [DATA_W-1:0]   data_out,
  output logic [2:0]          state,
  output logic                idle
);

  function automatic logic [WEIGHT_W-1:0] fix_weight(input logic [WEIGHT_W-1:0] w);
    fix_weight = (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  state_t              r_state;
  logic [WEIGHT_W-1:0] r_weight_vc0;
  logic [WEIGHT_W-1:0] r_weight_vc1;
  logic                r_push_d0;
  logic                r_push_d1;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_idle;

  state_t              w_state_nxt;
  logic                w_af_vc0;
  logic                w_af_vc1;
  logic [1:0]          w_elig;
  logic                w_grant_en;
  logic [1:0]          w_grant;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_dest;

  // Backpressure is judged on the head word's own destination only.
  assign w_af_vc0 = data_in_VC0[DEST_BIT] ? almost_full_D1 : almost_full_D0;
  assign w_af_vc1 = data_in_VC1[DEST_BIT] ? almost_full_D1 : almost_full_D0;
  assign w_elig   = {~empty_VC1 & ~w_af_vc1, ~empty_VC0 & ~w_af_vc0};

  // init in ACTIVE pre-empts the grant in the same cycle.
  assign w_grant_en = (r_state == ST_ACTIVE) && !init;

  vc_dest_arbiter_wrr_grant #(
    .WEIGHT_W(WEIGHT_W)
  ) u_wrr_grant (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_grant_en),
    .i_elig      (w_elig),
    .i_weight_vc0(r_weight_vc0),
    .i_weight_vc1(r_weight_vc1),
    .o_grant     (w_grant)
  );

  assign pop_VC0    = w_grant[VC0];
  assign pop_VC1    = w_grant[VC1];
  assign w_sel_data = w_grant[VC1] ? data_in_VC1 : data_in_VC0;
  assign w_sel_dest = w_sel_data[DEST_BIT];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RESET:  w_state_nxt = ST_INIT;
      ST_INIT:   w_state_nxt = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (init)           w_state_nxt = ST_INIT;
        else if (|w_elig)   w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)                       w_state_nxt = ST_INIT;
        else if (empty_VC0 && empty_VC1) w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RESET;
      r_weight_vc0 <= '0;
      r_weight_vc1 <= '0;
      r_push_d0    <= 1'b0;
      r_push_d1    <= 1'b0;
      r_data_out   <= '0;
      r_idle       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idle    <= (w_state_nxt == ST_IDLE);
      if (r_state == ST_INIT) begin
        r_weight_vc0 <= fix_weight(cfg_weight_VC0);
        r_weight_vc1 <= fix_weight(cfg_weight_VC1);
      end
      // Output stage: word popped this cycle is pushed at this edge.
      r_push_d0 <= (|w_grant) && !w_sel_dest;
      r_push_d1 <= (|w_grant) && w_sel_dest;
      if (|w_grant) r_data_out <= w_sel_data;
    end
  end

  assign push_D0  = r_push_d0;
  assign push_D1  = r_push_d1;
  assign data_out = r_data_out;
  assign state    = r_state;
  assign idle     = r_idle;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
module tb_vc_dest_arbiter;

  localparam int DW = 6;
  localparam int DB = 4;
  localparam int WW = 3;

  logic          clk = 1'b0;
  logic          reset, init;
  logic [WW-1:0] cfg_weight_VC0, cfg_weight_VC1;
  logic [DW-1:0] data_in_VC0, data_in_VC1;
  logic          empty_VC0, empty_VC1, almost_full_D0, almost_full_D1;
  logic          pop_VC0, pop_VC1, push_D0, push_D1, idle;
  logic [DW-1:0] data_out;
  logic [2:0]    state;

  always #5 clk = ~clk;

  vc_dest_arbiter dut (
    .clk(clk), .reset(reset), .init(init),
    .cfg_weight_VC0(cfg_weight_VC0), .cfg_weight_VC1(cfg_weight_VC1),
    .data_in_VC0(data_in_VC0), .data_in_VC1(data_in_VC1),
    .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
    .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
    .push_D0(push_D0), .push_D1(push_D1), .data_out(data_out),
    .state(state), .idle(idle)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source FIFO contents as seen by the scheduler
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Reference model: state code, latched weights, quota counter, last VC
  int            m_state = 0, m_w0 = 0, m_w1 = 0, m_cnt = 0, m_cur = 0;
  logic          m_p0 = 0, m_p1 = 0, m_idle = 0;
  logic [DW-1:0] m_dout = '0;

  bit rst_on_pop1 = 0;
  int pop1_resets = 0;
  bit log_en = 0;
  int pop_log[$];

  task automatic drive_heads();
    if (q0.size() > 0) begin data_in_VC0 = q0[0]; empty_VC0 = 1'b0; end
    else begin data_in_VC0 = DW'($urandom); empty_VC0 = 1'b1; end
    if (q1.size() > 0) begin data_in_VC1 = q1[0]; empty_VC1 = 1'b0; end
    else begin data_in_VC1 = DW'($urandom); empty_VC1 = 1'b1; end
  endtask

  // One clock cycle: predict pops, check them, predict registered outputs, check after edge.
  task automatic cycle();
    bit            el[2];
    int            g, wt, nxt;
    logic [DW-1:0] gd;
    drive_heads();
    #1;
    el[0] = !empty_VC0 && !(data_in_VC0[DB] ? almost_full_D1 : almost_full_D0);
    el[1] = !empty_VC1 && !(data_in_VC1[DB] ? almost_full_D1 : almost_full_D0);
    g = -1;
    if (m_state == 3 && !init) begin
      wt = (m_cur == 0) ? m_w0 : m_w1;
      if (el[m_cur] && m_cnt < wt) begin
        g = m_cur;
        if (m_cnt < 7) m_cnt++;
      end else if (el[1-m_cur]) begin
        g = 1 - m_cur; m_cur = g; m_cnt = 1;
      end else if (el[m_cur]) begin
        g = m_cur; m_cnt = 1;
      end
    end
    if (rst_on_pop1 && g == 1) begin
      reset = 1'b1; rst_on_pop1 = 0; pop1_resets++;
    end
    chk("pop_VC0", 32'(pop_VC0), 32'(g == 0));
    chk("pop_VC1", 32'(pop_VC1), 32'(g == 1));
    if (log_en && g >= 0) pop_log.push_back(g);
    gd = (g == 1) ? data_in_VC1 : data_in_VC0;
    case (m_state)
      0:       nxt = 1;
      1:       nxt = init ? 1 : 2;
      2:       nxt = init ? 1 : ((el[0] || el[1]) ? 3 : 2);
      default: nxt = init ? 1 : ((empty_VC0 && empty_VC1) ? 2 : 3);
    endcase
    if (m_state == 1) begin
      m_w0 = (cfg_weight_VC0 == 0) ? 1 : int'(cfg_weight_VC0);
      m_w1 = (cfg_weight_VC1 == 0) ? 1 : int'(cfg_weight_VC1);
    end
    m_p0 = (g >= 0) && !gd[DB];
    m_p1 = (g >= 0) && gd[DB];
    if (g >= 0) m_dout = gd;
    m_state = nxt;
    m_idle  = (nxt == 2);
    if (reset) begin
      m_state = 0; m_w0 = 0; m_w1 = 0; m_cnt = 0; m_cur = 0;
      m_p0 = 0; m_p1 = 0; m_dout = '0; m_idle = 0;
    end
    if (g == 0) void'(q0.pop_front());
    if (g == 1) void'(q1.pop_front());
    @(posedge clk);
    #1;
    chk("state",    32'(state),    32'(m_state));
    chk("idle",     32'(idle),     32'(m_idle));
    chk("push_D0",  32'(push_D0),  32'(m_p0));
    chk("push_D1",  32'(push_D1),  32'(m_p1));
    chk("data_out", 32'(data_out), 32'(m_dout));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(q0.size() + q1.size()), 32'd0);
    cycle();
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    reset = 1; init = 0; almost_full_D0 = 0; almost_full_D1 = 0;
    cfg_weight_VC0 = 3'd2; cfg_weight_VC1 = 3'd1;
    drive_heads();
    @(posedge clk);
    #1;

    // Reset and init sequence
    cycle();
    cycle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_push",  32'({push_D0, push_D1}), 32'd0);
    reset = 0; init = 1;
    cycle();
    chk("seq_init", 32'(state), 32'd1);
    cycle();
    init = 0;
    cycle();
    chk("seq_idle", 32'(state), 32'd2);
    chk("seq_idle_flag", 32'(idle), 32'd1);

    // Weighted share 2:1, no backpressure
    for (int i = 0; i < 6; i++) begin
      q0.push_back(DW'(i + 8'h20));
      q1.push_back(DW'(i + 8'h08));
    end
    log_en = 1;
    drain(40);
    log_en = 0;
    for (int i = 0; i < 12; i++)
      chk("wrr_order", 32'((i < pop_log.size()) ? pop_log[i] : -1), 32'(exp_order[i]));
    chk("empty_idle_state", 32'(state), 32'd2);
    chk("empty_idle_flag",  32'(idle),  32'd1);

    // Routing by header bit
    q0.push_back(6'b110100);
    q0.push_back(6'b100101);
    drain(10);

    // Backpressure on D1 holds VC0 whose head targets D1
    almost_full_D1 = 1;
    q0.push_back(6'b110110);
    q1.push_back(6'b100100);
    q1.push_back(6'b100100);
    for (int i = 0; i < 5; i++) cycle();
    chk("bp_vc0_held", 32'(q0.size()), 32'd1);
    almost_full_D1 = 0;
    drain(10);

    // Randomized traffic, backpressure, weight reloads and rare resets
    for (int i = 0; i < 1500; i++) begin
      if (q0.size() < 8 && $urandom_range(0, 2) == 0) q0.push_back(DW'($urandom));
      if (q1.size() < 8 && $urandom_range(0, 2) == 0) q1.push_back(DW'($urandom));
      almost_full_D0 = ($urandom_range(0, 3) == 0);
      almost_full_D1 = ($urandom_range(0, 3) == 0);
      cfg_weight_VC0 = WW'($urandom);
      cfg_weight_VC1 = WW'($urandom);
      init  = (init && $urandom_range(0, 1) == 0) || ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end

    // Reset in the same cycle as a VC1 pop
    reset = 0; init = 1; almost_full_D0 = 0; almost_full_D1 = 0;
    cfg_weight_VC0 = 3'd1; cfg_weight_VC1 = 3'd3;
    cycle();
    cycle();
    init = 0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 4; i++) q1.push_back(DW'(8'h31 + i));
    rst_on_pop1 = 1;
    for (int i = 0; i < 12 && pop1_resets == 0; i++) cycle();
    chk("mid_reset_hit",   32'(pop1_resets), 32'd1);
    chk("mid_reset_state", 32'(state),       32'd0);
    chk("mid_reset_push",  32'({push_D0, push_D1}), 32'd0);
    chk("mid_reset_data",  32'(data_out),    32'd0);
    reset = 0;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) in the transmit-layer final logic.
- Each cycle it picks at most one VC word using weighted round-robin, pops it, and pushes it one cycle later into the destination FIFO selected by a header bit.
- Handles source empty flags, destination almost-full backpressure, and a config/init phase that latches the weights.

Parameters:
- DATA_W, 6, word width of the VC and destination data.
- DEST_BIT, 4, index of the data bit that selects the destination (0 = D0, 1 = D1).
- WEIGHT_W, 3, width of the per-VC weight fields and the grant counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  level; while high the block sits in INIT and latches weights.
- cfg_weight_VC0  in  WEIGHT_W  consecutive grants allowed to VC0; 0 is treated as 1.
- cfg_weight_VC1  in  WEIGHT_W  consecutive grants allowed to VC1; 0 is treated as 1.
- data_in_VC0  in  DATA_W  head word of the VC0 FIFO (show-ahead, valid while !empty_VC0).
- data_in_VC1  in  DATA_W  head word of the VC1 FIFO.
- empty_VC0  in  1  VC0 FIFO empty.
- empty_VC1  in  1  VC1 FIFO empty.
- almost_full_D0  in  1  D0 FIFO almost full; the threshold leaves at least 2 free slots.
- almost_full_D1  in  1  D1 FIFO almost full.
- pop_VC0  out  1  pop VC0 head (combinational, same cycle as grant).
- pop_VC1  out  1  pop VC1 head.
- push_D0  out  1  registered push into D0.
- push_D1  out  1  registered push into D1.
- data_out  out  DATA_W  registered word accompanying push_D0/push_D1.
- state  out  3  current FSM state code.
- idle  out  1  registered; high in IDLE.

Behaviour:
- Reset (reset=1 at an edge):
  - state = RESET (000); all latched registers cleared.
  - Outputs: pop_VC0 = 0, pop_VC1 = 0, push_D0 = 0, push_D1 = 0, data_out = 0, idle = 0.
  - The grant counter and last-grant pointer (cur_vc = VC0) are cleared.
  - Reset asserted mid-transfer drops any in-flight push; no push occurs in the cycle after reset.
- FSM codes: RESET=000, INIT=001, IDLE=010, ACTIVE=011.
- RESET -> INIT on the first edge with reset=0.
- INIT:
  - Weights are latched every cycle; a latched value of 0 is stored as 1.
  - No pops are issued.
  - Exits to IDLE on the first edge with init=0.
- IDLE: idle=1. Moves to ACTIVE at the edge where either VC is eligible.
- ACTIVE:
  - One grant per cycle while any VC is eligible.
  - Returns to IDLE when both VCs are empty at an edge.
- init=1 in IDLE or ACTIVE forces INIT at the next edge and suppresses pops in that same cycle. A push already registered still completes.
- Eligibility: VCx is eligible when !empty_VCx and !almost_full_D[data_in_VCx[DEST_BIT]].
  - No head-of-line bypass: a VC whose head is blocked is ineligible even if later words could route elsewhere.
- Weighted round-robin:
  - If cur_vc is eligible and cnt < weight[cur_vc], grant cur_vc and increment cnt.
  - Otherwise, if the other VC is eligible, grant it, set cur_vc to it and set cnt = 1.
  - Otherwise, if cur_vc is still eligible (quota exhausted), grant cur_vc and set cnt = 1.
  - Otherwise, no grant.
  - The counter saturates; it never wraps.
- Grant timing:
  - In cycle N, the granted pop_VCx is high combinationally.
  - At edge N+1: data_out <= data_in_VCx, and push_D[data_in_VCx[DEST_BIT]] <= 1.
  - The other push is 0 in that cycle.
  - Latency from pop to push is 1 cycle.
- pop_VC0 and pop_VC1 are never both high in the same cycle.
- push_D0 and push_D1 are never both high in the same cycle.
- Pops stay 0 outside ACTIVE. The IDLE->ACTIVE transition cycle itself issues no pop.
- data_out holds its last value when no push is active.

Decomposition:
- Shared package: FSM state codes (RESET/INIT/IDLE/ACTIVE), DATA_W, DEST_BIT, WEIGHT_W, and the VC index constants (VC0=0, VC1=1).
- Sub-module wrr_grant: eligibility vector plus counter/pointer in, one-hot grant out, with counter and pointer update.
- The top level holds the FSM and the output pipeline register.

Test Plan:
- Reset/init: reset=1 for 2 cycles, then init=1 with weights 2/1, then init=0. Required: state sequence 000 -> 001 -> 010; all outputs 0 during reset; no pops while in INIT.
- Weighted share: both VCs non-empty with 6 words each, no backpressure, weights 2/1. Required pop order: VC0, VC0, VC1, VC0, VC0, VC1, ...; each word appears on data_out 1 cycle after its pop.
- Routing: VC0 head 6'b110100 (bit4=1) and 6'b100101 (bit4=0). Required: push_D1 with data_out=110100, then push_D0 with data_out=100101.
- Backpressure: almost_full_D1=1 while VC0 head 6'b110110 and VC1 head 6'b100100. Required: only VC1 is popped; VC0 resumes the cycle after almost_full_D1 drops.
- Empty/idle: both VCs go empty after the last pop. Required: the last push follows 1 cycle after the last pop, and state returns to 010 with idle=1.
- Reset mid-stream: reset=1 in the same cycle as pop_VC1. Required: no push on the next edge; state=000; data_out=0.
